// File: rtl/wishbone_pkg.sv
// Shared types and limits for the pipelined Wishbone SRAM target.
package wishbone_pkg;

  localparam int MaxReadLatency = 4;

  // One slot of the response delay line; err and we only matter while valid is set.
  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } resp_stage_t;

endpackage

// File: rtl/wishbone_resp_pipe.sv
// Fixed-length response delay line with a synchronous flush and async active-low reset.
module wishbone_resp_pipe
  import wishbone_pkg::*;
#(
  parameter int  Depth = 1,
  parameter type ElemT = resp_stage_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  ElemT in_elem,
  output ElemT out_elem
);

  ElemT stage [Depth];

  // A flush zeroes every slot, which also drops its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_elem;
      for (int i = 1; i < Depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_elem = stage[Depth-1];

endmodule

// File: rtl/wishbone_sram_target.sv
// Pipelined Wishbone target that forwards requests straight to an SRAM port and
// terminates every accepted request a fixed ReadLatency cycles later.
module wishbone_sram_target
  import wishbone_pkg::*;
#(
  parameter int              AddressWidth = 16,
  parameter int              DataWidth    = 8,
  parameter int              Granularity  = 8,
  parameter longint unsigned MemWords     = 64'd1 << AddressWidth,
  parameter int              ReadLatency  = 1,
  localparam int             SELWidth     = DataWidth / Granularity
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [AddressWidth-1:0] ADDR,
  input  logic [DataWidth-1:0]    DAT_ToTarget,
  input  logic [SELWidth-1:0]     SEL,
  output logic                    STALL,
  output logic                    ACK,
  output logic                    ERR,
  output logic [DataWidth-1:0]    DAT_ToInitiator,
  output logic                    BUSY,
  output logic                    MEM_EN,
  output logic                    MEM_WE,
  output logic [AddressWidth-1:0] MEM_ADDR,
  output logic [DataWidth-1:0]    MEM_WDATA,
  output logic [SELWidth-1:0]     MEM_BE,
  input  logic [DataWidth-1:0]    MEM_RDATA,
  input  logic                    MEM_READY
);

  localparam int Depth = (ReadLatency < 1) ? 1 :
                         (ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency;
  localparam int CntWidth = $clog2(Depth + 1);

  logic                accept;
  logic                in_range;
  logic                issue;
  resp_stage_t         new_resp;
  resp_stage_t         exit_resp;
  logic [CntWidth-1:0] outstanding;

  // Nothing is accepted while reset is held, so no SRAM command can leak out.
  assign STALL    = ~MEM_READY;
  assign accept   = RST & CYC & STB & MEM_READY;
  assign in_range = 64'(ADDR) < MemWords;
  assign issue    = accept & in_range & (~WE | (|SEL));

  assign MEM_EN    = issue;
  assign MEM_WE    = issue & WE;
  assign MEM_ADDR  = issue ? ADDR : '0;
  assign MEM_WDATA = issue ? DAT_ToTarget : '0;
  assign MEM_BE    = issue ? SEL : '0;

  assign new_resp = resp_stage_t'{valid: accept, err: ~in_range, we: WE};

  wishbone_resp_pipe #(
    .Depth (Depth),
    .ElemT (resp_stage_t)
  ) u_resp_pipe (
    .clk      (CLK),
    .rst_n    (RST),
    .flush    (~CYC),
    .in_elem  (new_resp),
    .out_elem (exit_resp)
  );

  assign ACK             = exit_resp.valid & ~exit_resp.err & CYC;
  assign ERR             = exit_resp.valid & exit_resp.err & CYC;
  assign DAT_ToInitiator = (ACK & ~exit_resp.we) ? MEM_RDATA : '0;

  // Tracks requests in flight; dropping CYC abandons them along with the pipeline.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      outstanding <= '0;
    end else if (!CYC) begin
      outstanding <= '0;
    end else if (accept && !exit_resp.valid) begin
      outstanding <= outstanding + CntWidth'(1);
    end else if (!accept && exit_resp.valid) begin
      outstanding <= outstanding - CntWidth'(1);
    end
  end

  assign BUSY = |outstanding;

endmodule

// File: doc/wishbone_sram_target.md
WISHBONE_SRAM_TARGET -- requirements
Module: wishbone_sram_target

Interface
REQ-001 Parameter AddressWidth, default 16, Wishbone word-address width.
REQ-002 Parameter DataWidth, default 8, data bits (8/16/32/64).
REQ-003 Parameter Granularity, default 8, bits per SEL lane; SELWidth = DataWidth/Granularity.
REQ-004 Parameter MemWords, default 2**AddressWidth, number of implemented words.
REQ-005 Parameter ReadLatency, default 1, SRAM read latency in cycles, legal range 1..4.
REQ-006 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 CLK  in  1  sole clock, rising edge.
REQ-008 RST  in  1  asynchronous active-low reset.
REQ-009 CYC, STB, WE  in  1 each  pipelined Wishbone cycle, strobe and write enable, from the upstream skid buffer.
REQ-010 ADDR  in  AddressWidth  word address.
REQ-011 DAT_ToTarget  in  DataWidth  write data.
REQ-012 SEL  in  SELWidth  byte-lane selects.
REQ-013 STALL  out  1  pipelined stall.
REQ-014 ACK, ERR  out  1 each  termination strobes.
REQ-015 DAT_ToInitiator  out  DataWidth  read data.
REQ-016 BUSY  out  1  high while any response is outstanding.
REQ-017 MEM_EN, MEM_WE  out  1 each  SRAM command strobe and write enable.
REQ-018 MEM_ADDR  out  AddressWidth; MEM_WDATA  out  DataWidth; MEM_BE  out  SELWidth.
REQ-019 MEM_RDATA  in  DataWidth  SRAM read data, valid exactly ReadLatency cycles after a read MEM_EN.
REQ-020 MEM_READY  in  1  SRAM arbiter grant; low means no command may issue this cycle.

Function
REQ-021 STALL SHALL equal ~MEM_READY, combinational.
REQ-022 A request is accepted when CYC & STB & ~STALL; at most one per cycle.
REQ-023 Accepted request with ADDR < MemWords and (~WE or SEL != 0) SHALL drive MEM_EN=1 in the same cycle, with MEM_ADDR=ADDR, MEM_WE=WE, MEM_WDATA=DAT_ToTarget, MEM_BE=SEL.
REQ-024 Accepted write with SEL == 0 SHALL issue no MEM_EN yet be acknowledged normally.
REQ-025 Accepted request with ADDR >= MemWords SHALL issue no MEM_EN and be terminated with ERR instead of ACK.
REQ-026 Every accepted request SHALL enter a response pipeline of ReadLatency stages (valid, err, we); reads, writes and errors all terminate exactly ReadLatency cycles after acceptance, preserving order.
REQ-027 At pipeline exit: ACK = valid & ~err & CYC; ERR = valid & err & CYC; never both high.
REQ-028 DAT_ToInitiator SHALL equal MEM_RDATA when ACK of a read is asserted, else zero.
REQ-029 When MEM_EN=0, MEM_ADDR, MEM_WDATA, MEM_BE and MEM_WE SHALL be zero.
REQ-030 CYC low SHALL force ACK/ERR low combinationally and clear all pipeline valid bits on the next edge; SRAM commands already issued complete (writes remain performed).
REQ-031 Outstanding counter: +1 on accept, -1 on pipeline exit, both same cycle -> unchanged, cleared on CYC drop; width clog2(ReadLatency+1), never exceeds ReadLatency; BUSY = counter != 0.
REQ-032 CYC dropped and reasserted in consecutive cycles SHALL not deliver any termination belonging to the earlier cycle.

Reset
REQ-033 RST low SHALL immediately clear pipeline valid bits and counter: ACK=0, ERR=0, BUSY=0, DAT_ToInitiator=0, MEM_EN=0; STALL follows MEM_READY.
REQ-034 Reset mid-burst SHALL discard all outstanding responses; no termination emitted after RST deasserts for pre-reset requests.

Structure
REQ-035 Response-stage struct (valid, err, we) and latency bound constant SHALL live in shared package wishbone_pkg.
REQ-036 The response delay line with flush SHALL be sub-module wishbone_resp_pipe (parameters Depth, element type); all else in wishbone_sram_target.

Verification
REQ-037 ReadLatency=2, MEM_READY=1: write 0xA5 to addr 0x0010 SEL=1, then read 0x0010 back-to-back -> write ACK at cycle+2, read ACK cycle+3 with DAT_ToInitiator=0xA5.
REQ-038 MemWords=256: read addr 0x0100 -> no MEM_EN, ERR exactly ReadLatency cycles later, ACK=0, data 0.
REQ-039 Four back-to-back reads, MEM_READY low on the 2nd attempt -> STALL=1 that cycle, four ACKs in address order, BUSY falls after the last.
REQ-040 ReadLatency=3, 3 reads issued then CYC low at next cycle -> no ACK/ERR, counter 0, BUSY 0 one cycle later.
REQ-041 Write with SEL=0 -> MEM_EN stays 0, ACK after ReadLatency cycles.
REQ-042 RST low for one cycle with 2 outstanding reads -> ACK/ERR/BUSY zero immediately and stay zero until a new request is accepted.
